// File: rtl/signal_frame_pkg.sv
// signal_frame_pkg
//   Shared definitions for the signal_frame capture buffer: FSM state
//   encoding, default sample width and frame geometry, and a helper that
//   turns a log2 depth into a frame length.
package signal_frame_pkg;

    // Encoding is visible on the o_state debug probe, so values are fixed.
    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_READ  = 2'd3
    } state_t;

    localparam int SAMPLE_WIDTH_DEF = 12;
    localparam int DEPTH_LOG2_DEF   = 10;
    localparam int FRAME_LEN_DEF    = 1 << DEPTH_LOG2_DEF;

    function automatic int frame_len(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/signal_frame_if.sv
// signal_frame_if
//   Bundles the ADC, trigger and transfer-controller handshake of the
//   capture buffer.
//   Inputs to the buffer : i_adc_valid, i_adc_data, i_trigger_pulse,
//                          i_rd_en, i_rearm
//   Outputs of the buffer: o_sample_valid, o_sample_data,
//                          o_capture_done, o_state
//   master: the side that drives the i_* signals (ADC / controller).
//   slave : the capture buffer itself.
interface signal_frame_if import signal_frame_pkg::*; #(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
);
    logic                    i_adc_valid;
    logic [SAMPLE_WIDTH-1:0] i_adc_data;
    logic                    i_trigger_pulse;
    logic                    i_rd_en;
    logic                    i_rearm;
    logic                    o_sample_valid;
    logic [SAMPLE_WIDTH-1:0] o_sample_data;
    logic                    o_capture_done;
    logic [1:0]              o_state;

    modport master (
        output i_adc_valid, i_adc_data, i_trigger_pulse, i_rd_en, i_rearm,
        input  o_sample_valid, o_sample_data, o_capture_done, o_state
    );

    modport slave (
        input  i_adc_valid, i_adc_data, i_trigger_pulse, i_rd_en, i_rearm,
        output o_sample_valid, o_sample_data, o_capture_done, o_state
    );
endinterface

// File: rtl/signal_frame_ram.sv
// frame_ram
//   Simple dual-port RAM for the capture ring: one write port, one read
//   port with a registered output (one-cycle read latency).
//   clk, rst         : clock, asynchronous active-high reset (output reg only)
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request; rd_data is valid the following cycle
//   rd_data          : registered read data, holds between reads
module frame_ram import signal_frame_pkg::*; #(
    parameter int WIDTH  = SAMPLE_WIDTH_DEF,
    parameter int ADDR_W = DEPTH_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [0:(1 << ADDR_W) - 1];

    // NOTE: the array itself is never reset so it maps onto block RAM;
    // only the output register is cleared, which the sample port needs.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/signal_frame.sv
// signal_frame
//   Pre/post-trigger capture buffer in front of the UART transfer
//   controller. ADC samples stream into a circular RAM; after a trigger the
//   frame of 2^DEPTH_LOG2 samples (PRE_TRIG of them before the trigger) is
//   frozen and served oldest-first, one sample per read request.
//   i_clk, i_RESET : clock, asynchronous active-high reset
//   bus (slave)    : ADC input, trigger, read/re-arm requests, sample
//                    output, completion flag and FSM debug probe
module signal_frame import signal_frame_pkg::*; #(
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int DEPTH_LOG2   = DEPTH_LOG2_DEF,
    parameter int PRE_TRIG     = 256
) (
    input  logic           i_clk,
    input  logic           i_RESET,
    signal_frame_if.slave  bus
);
    localparam int FRAME_LEN = frame_len(DEPTH_LOG2);
    localparam int POST_LEN  = FRAME_LEN - PRE_TRIG;
    // One spare bit so every terminal count is representable.
    localparam int CNT_W     = DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(PRE_TRIG - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_LEN - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(FRAME_LEN - 1);

    state_t                  state, state_nxt;
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        fill_cnt, post_cnt, rd_cnt;
    logic                    rd_pending;
    logic                    sample_valid, capture_done;
    logic                    wr_en, rd_issue, rearm_ok;
    logic [SAMPLE_WIDTH-1:0] ram_q;

    // State register.
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values regardless of process order.
    always_ff @(posedge i_clk or posedge i_RESET) begin
        if (i_RESET) state <= S_FILL;
        else         state <= state_nxt;
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL:  if (wr_en && fill_cnt == FILL_LAST) state_nxt = S_ARMED;
            // A trigger that carries its own sample can finish a one-sample
            // post window immediately.
            S_ARMED: if (bus.i_trigger_pulse)
                         state_nxt = (wr_en && POST_LEN == 1) ? S_READ : S_POST;
            S_POST:  if (wr_en && post_cnt == POST_LAST) state_nxt = S_READ;
            S_READ:  if (rearm_ok) state_nxt = S_FILL;
            default: state_nxt = S_FILL;
        endcase
    end

    // Output/strobe decode.
    always_comb begin
        wr_en    = bus.i_adc_valid && (state != S_READ);
        rearm_ok = bus.i_rearm && capture_done;
        // A request parked while the frame was still filling is served on
        // the first S_READ cycle; after completion requests are ignored.
        rd_issue = (state == S_READ) && !capture_done && (bus.i_rd_en || rd_pending);
    end

    // Pointers, counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_RESET) begin
        if (i_RESET) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_cnt     <= '0;
            post_cnt     <= '0;
            rd_cnt       <= '0;
            rd_pending   <= 1'b0;
            sample_valid <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            sample_valid <= rd_issue;

            if (wr_en) wr_ptr <= wr_ptr + 1'b1;

            if (rearm_ok)                      fill_cnt <= '0;
            else if (state == S_FILL && wr_en) fill_cnt <= fill_cnt + 1'b1;

            // The trigger sample itself is post sample 1.
            if (state == S_ARMED && bus.i_trigger_pulse)
                post_cnt <= wr_en ? CNT_W'(1) : '0;
            else if (state == S_POST && wr_en)
                post_cnt <= post_cnt + 1'b1;

            // Entering S_READ always coincides with a write, so the slot
            // after the one being written holds the oldest frame sample.
            if (state != S_READ && state_nxt == S_READ) begin
                rd_ptr <= wr_ptr + 1'b1;
                rd_cnt <= '0;
            end else if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_cnt <= rd_cnt + 1'b1;
            end

            if (rd_issue && rd_cnt == RD_LAST) capture_done <= 1'b1;
            else if (rearm_ok)                 capture_done <= 1'b0;

            // Requests outside S_READ (including the re-arm cycle) are kept.
            if (bus.i_rd_en && (state != S_READ || rearm_ok)) rd_pending <= 1'b1;
            else if (rd_issue)                                rd_pending <= 1'b0;
        end
    end

    frame_ram #(
        .WIDTH  (SAMPLE_WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk     (i_clk),
        .rst     (i_RESET),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (bus.i_adc_data),
        .rd_en   (rd_issue),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    assign bus.o_sample_valid = sample_valid;
    assign bus.o_sample_data  = ram_q;
    assign bus.o_capture_done = capture_done;
    assign bus.o_state        = state;
endmodule

// File: tb/tb_signal_frame.sv
// tb_signal_frame
//   Directed/randomised bench for signal_frame with DEPTH_LOG2=4, PRE_TRIG=4.
//   The reference model keeps the list of samples written since the last
//   (re)arm and the index of the accepted trigger; the expected frame is the
//   last 16 entries of that list once the post window is full.
module tb_signal_frame;
    import signal_frame_pkg::*;

    localparam int SW    = 12;
    localparam int DL    = 4;
    localparam int PRE   = 4;
    localparam int FRAME = 1 << DL;
    localparam int POST  = FRAME - PRE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    signal_frame_if #(.SAMPLE_WIDTH(SW)) bus ();

    signal_frame #(
        .SAMPLE_WIDTH (SW),
        .DEPTH_LOG2   (DL),
        .PRE_TRIG     (PRE)
    ) dut (
        .i_clk   (clk),
        .i_RESET (rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int ramp    = 0;

    // Reference model state.
    logic [SW-1:0] cap [$];
    int            trig_at = -1;
    int            rd_idx  = 0;
    bit            pend    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_complete();
        return trig_at >= 0 && cap.size() >= trig_at + POST;
    endfunction

    function automatic bit m_done();
        return m_complete() && rd_idx >= FRAME;
    endfunction

    function automatic int m_state();
        if (m_complete())          return 3;
        if (trig_at >= 0)          return 2;
        if (cap.size() >= PRE)     return 1;
        return 0;
    endfunction

    function automatic logic [SW-1:0] m_frame(input int i);
        return cap[cap.size() - FRAME + i];
    endfunction

    task automatic m_arm();
        cap.delete();
        trig_at = -1;
        rd_idx  = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_adc_valid     = 1'b0;
        bus.i_trigger_pulse = 1'b0;
        bus.i_rd_en         = 1'b0;
        bus.i_rearm         = 1'b0;
    endtask

    // One sample cycle followed by one idle cycle.
    task automatic send(input logic [SW-1:0] d, input bit trig, input bit rd);
        if (!m_complete()) begin
            if (rd) pend = 1'b1;
            if (trig && trig_at < 0 && cap.size() >= PRE) trig_at = cap.size();
            cap.push_back(d);
        end
        bus.i_adc_valid     = 1'b1;
        bus.i_adc_data      = d;
        bus.i_trigger_pulse = trig;
        bus.i_rd_en         = rd;
        step();
        clear_inputs();
        step();
        check("sample state", bus.o_state, m_state());
    endtask

    task automatic send_ramp(input bit trig, input bit rd);
        send(SW'(ramp), trig, rd);
        ramp++;
    endtask

    task automatic pulse_trigger();
        if (!m_complete() && trig_at < 0 && cap.size() >= PRE) trig_at = cap.size();
        bus.i_trigger_pulse = 1'b1;
        step();
        clear_inputs();
        step();
        check("trigger-only state", bus.o_state, m_state());
    endtask

    // Called right after the sample that completes the post window.
    task automatic check_entry(input string tag);
        bit exp_v;
        exp_v = pend;
        check({tag, " entry state"}, bus.o_state, 3);
        check({tag, " pending valid"}, bus.o_sample_valid, exp_v);
        if (exp_v) begin
            check({tag, " pending data"}, bus.o_sample_data, m_frame(0));
            rd_idx = 1;
            pend   = 1'b0;
        end
        check({tag, " entry done"}, bus.o_capture_done, rd_idx >= FRAME);
        step();
        check({tag, " no repeat strobe"}, bus.o_sample_valid, 0);
    endtask

    task automatic do_read(input string tag);
        bit            exp_v;
        logic [SW-1:0] exp_d;
        exp_v = rd_idx < FRAME;
        exp_d = '0;
        if (exp_v) begin
            exp_d = m_frame(rd_idx);
            rd_idx++;
        end
        bus.i_rd_en = 1'b1;
        step();
        bus.i_rd_en = 1'b0;
        check({tag, " valid"}, bus.o_sample_valid, exp_v);
        if (exp_v) check({tag, " data"}, bus.o_sample_data, exp_d);
        check({tag, " done"}, bus.o_capture_done, rd_idx >= FRAME);
        step();
        check({tag, " single strobe"}, bus.o_sample_valid, 0);
        repeat ($urandom_range(0, 6)) step();
    endtask

    task automatic rearm(input bit rd);
        bit was_done;
        was_done = m_done();
        bus.i_rearm = 1'b1;
        bus.i_rd_en = rd;
        step();
        clear_inputs();
        if (was_done) begin
            m_arm();
            if (rd) pend = 1'b1;
        end
        check("rearm done", bus.o_capture_done, m_done());
        check("rearm state", bus.o_state, m_state());
        step();
    endtask

    task automatic capture_until_complete(input string tag, input bit random_data);
        int guard;
        guard = 0;
        while (!m_complete() && guard < 64) begin
            if (random_data) send(SW'($urandom), 1'b0, 1'b0);
            else             send_ramp(1'b0, 1'b0);
            guard++;
        end
        check({tag, " completed in budget"}, m_complete(), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        clear_inputs();
        bus.i_adc_data = '0;

        // Reset values.
        repeat (3) step();
        check("reset valid", bus.o_sample_valid, 0);
        check("reset data",  bus.o_sample_data, 0);
        check("reset done",  bus.o_capture_done, 0);
        check("reset state", bus.o_state, 0);
        rst = 1'b0;
        m_arm();
        step();

        // Frame 1: early trigger ignored, trigger on the FILL->ARMED write
        // ignored, real trigger with sample 20 plus a coincident rd_en.
        send_ramp(1'b0, 1'b0);
        send_ramp(1'b0, 1'b0);
        pulse_trigger();
        send_ramp(1'b0, 1'b0);
        send_ramp(1'b1, 1'b0);
        check("armed after sample 3", bus.o_state, 1);
        while (ramp < 20) send_ramp(1'b0, 1'b0);
        send_ramp(1'b1, 1'b1);
        capture_until_complete("frame1", 1'b0);
        check_entry("frame1");
        check("frame1 first sample", bus.o_sample_data, 16);
        repeat (3) send(SW'($urandom), 1'b0, 1'b0);
        rearm(1'b0);
        for (int i = 0; i < FRAME - 1; i++) do_read("frame1 read");
        check("frame1 last sample", bus.o_sample_data, 31);
        do_read("frame1 extra read");
        repeat (5) step();
        check("frame1 done held", bus.o_capture_done, m_done());

        // Frame 2: re-arm with a coincident rd_en, trigger at sample 40,
        // read across the pointer wrap.
        rearm(1'b1);
        while (ramp < 40) send_ramp(1'b0, 1'b0);
        send_ramp(1'b1, 1'b0);
        capture_until_complete("frame2", 1'b0);
        check_entry("frame2");
        check("frame2 first sample", bus.o_sample_data, 36);
        for (int i = 0; i < FRAME - 1; i++) do_read("frame2 read");
        check("frame2 last sample", bus.o_sample_data, 51);

        // Frame 3: random data, random pre-trigger length, ignored re-arm
        // and re-trigger during the post window, reset after 5 reads.
        rearm(1'b0);
        k = $urandom_range(PRE, PRE + 5);
        repeat (k) send(SW'($urandom), 1'b0, 1'b0);
        send(SW'($urandom), 1'b1, 1'b0);
        send(SW'($urandom), 1'b1, 1'b0);
        rearm(1'b0);
        capture_until_complete("frame3", 1'b1);
        check_entry("frame3");
        for (int i = 0; i < 5; i++) do_read("frame3 read");
        bus.i_rd_en = 1'b1;
        step();
        bus.i_rd_en = 1'b0;
        check("frame3 read before reset", bus.o_sample_valid, rd_idx < FRAME);
        #2;
        rst = 1'b1;
        #1;
        check("async reset valid", bus.o_sample_valid, 0);
        check("async reset data",  bus.o_sample_data, 0);
        check("async reset done",  bus.o_capture_done, 0);
        check("async reset state", bus.o_state, 0);
        step();
        rst = 1'b0;
        m_arm();
        pend = 1'b0;
        step();

        // Frame 4: after reset, trigger at sample 60 with coincident rd_en.
        while (ramp < 60) send_ramp(1'b0, 1'b0);
        send_ramp(1'b1, 1'b1);
        capture_until_complete("frame4", 1'b0);
        check_entry("frame4");
        check("frame4 first sample", bus.o_sample_data, 56);
        for (int i = 0; i < FRAME - 1; i++) do_read("frame4 read");
        check("frame4 last sample", bus.o_sample_data, 71);
        do_read("frame4 extra read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/signal_frame.md
Name: signal_frame

Overview:
- Capture buffer that sits directly upstream of the UART transfer controller.
- Continuously writes ADC samples into a circular RAM. On a trigger it completes a frame of 2^DEPTH_LOG2 samples, with PRE_TRIG samples taken before the trigger.
- Then serves the frame one sample per read request, oldest first.
- Flags the last sample with o_capture_done and holds that flag until re-armed.

Parameters:
- SAMPLE_WIDTH, 12, ADC sample width in bits.
- DEPTH_LOG2, 10, log2 of the frame length (default 1024 samples).
- PRE_TRIG, 256, number of pre-trigger samples in the frame; legal range 1..2^DEPTH_LOG2-1.

Ports:
- i_clk  in  1  system clock (25 MHz).
- i_RESET  in  1  asynchronous, active-high reset.
- i_adc_valid  in  1  one-cycle strobe: i_adc_data holds a new sample.
- i_adc_data  in  SAMPLE_WIDTH  ADC sample.
- i_trigger_pulse  in  1  one-cycle trigger from the trigger generator.
- i_rd_en  in  1  one-cycle read request from the transfer controller.
- i_rearm  in  1  one-cycle pulse (the controller's transfer-done) that re-arms capture.
- o_sample_valid  out  1  one-cycle strobe: o_sample_data is valid.
- o_sample_data  out  SAMPLE_WIDTH  frame sample.
- o_capture_done  out  1  level: last frame sample has been delivered.
- o_state  out  2  debug probe of the FSM state.

Behaviour:
- Clock and reset:
  - Single clock i_clk.
  - Reset is asynchronous and active-high (i_RESET).
  - Reset values: o_sample_valid=0, o_sample_data=0, o_capture_done=0, o_state=S_FILL.
  - Reset also zeroes wr_ptr, rd_ptr, fill_cnt, post_cnt, rd_cnt and rd_pending.
  - Reset mid-operation aborts everything; the partial frame is discarded.
- States: S_FILL=0, S_ARMED=1, S_POST=2, S_READ=3. Completion is tracked in S_READ by o_capture_done.
- Writes:
  - In S_FILL, S_ARMED and S_POST, each i_adc_valid writes i_adc_data at wr_ptr, then wr_ptr increments modulo 2^DEPTH_LOG2 (natural wrap).
  - No writes occur in S_READ.
- S_FILL:
  - fill_cnt counts writes.
  - When the write that brings fill_cnt to PRE_TRIG occurs, move to S_ARMED.
  - Triggers in S_FILL are ignored.
- S_ARMED:
  - On i_trigger_pulse, move to S_POST with post_cnt=0.
  - If i_adc_valid occurs in the same cycle, that sample is the trigger sample and counts as post sample 1.
- S_POST:
  - Count writes, including the trigger sample, up to 2^DEPTH_LOG2-PRE_TRIG.
  - On the final write, move to S_READ with rd_ptr = wr_ptr after increment (the oldest sample) and rd_cnt=0.
  - Triggers in S_POST are ignored.
- S_READ:
  - A read is issued on i_rd_en, or in the first S_READ cycle if rd_pending=1 (rd_pending then clears).
  - A read at cycle N gives o_sample_valid=1 and o_sample_data=RAM[rd_ptr] at N+1 (one-cycle latency, registered RAM output).
  - Each read increments rd_ptr (with wrap) and rd_cnt.
  - On the read with rd_cnt = 2^DEPTH_LOG2-1, o_capture_done rises in the same cycle as that sample's o_sample_valid.
  - o_capture_done stays high until i_rearm.
  - After o_capture_done, further i_rd_en are ignored (no valid strobe).
- Pending reads:
  - i_rd_en outside S_READ sets rd_pending; it is never dropped.
  - The transfer controller raises rd_en on the trigger itself, before the frame is complete; rd_pending covers that case.
- Re-arm:
  - i_rearm while o_capture_done=1 clears o_capture_done and fill_cnt, and moves to S_FILL.
  - i_rearm at any other time is ignored.
- Simultaneous events:
  - i_rearm and i_rd_en in the same cycle: re-arm wins; the rd_en sets rd_pending.
  - i_trigger_pulse on the S_FILL-to-S_ARMED transition cycle is ignored.
- Only one read is outstanding at a time; o_sample_valid is never high for two consecutive cycles unless i_rd_en was.

Decomposition:
- Shared package holds:
  - state localparams (S_FILL, S_ARMED, S_POST, S_READ);
  - the SAMPLE_WIDTH default;
  - a frame-length constant derived from DEPTH_LOG2.
- Sub-module frame_ram: simple dual-port RAM, one write port and one read port, registered read, BRAM-inferable. The FSM and pointers stay in signal_frame.

Test Plan (DEPTH_LOG2=4, PRE_TRIG=4, i_adc_data a ramp 0,1,2,... with i_adc_valid every 2nd cycle):
- Reset: assert i_RESET asynchronously mid-clock -> all outputs 0 and o_state=0 immediately, without waiting for a clock edge.
- Early trigger: pulse trigger after 2 samples -> ignored; state reaches S_ARMED after sample 3; no frame is captured.
- Basic frame: trigger coincident with sample 20; rd_en pulsed 16 times, 8 cycles apart:
  - each valid arrives 1 cycle after its rd_en;
  - data = 16..31 in order;
  - o_capture_done rises with data 31 and stays high;
  - a 17th rd_en produces no valid.
- Pending read: rd_en coincident with the trigger -> o_sample_valid with data 16 one cycle after S_READ entry; no second strobe without a new rd_en.
- Wrap and re-arm: rearm, then trigger at sample 40 -> o_capture_done=0 after the rearm; frame reads 36..51 across the pointer wrap.
- Reset mid-S_READ after 5 reads -> outputs 0; the next capture with trigger at sample 60 reads 56..71 correctly.
